monitoreo_multicanal: RTL and testbench

MONITOREO_MULTICANAL -- requirements
Module: monitoreo_multicanal

---
 rtl/monitoreo_pkg.sv | 21 ++
 rtl/canal_temp.sv | 139 +++++++++++++
 rtl/monitoreo_multicanal.sv | 63 ++++++
 tb/tb_monitoreo_multicanal.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/monitoreo_pkg.sv
// Shared types for the multi-channel temperature monitor.
// Channel state codes and sample classes.
package monitoreo_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        FRIO     = 2'b01,
        CALIENTE = 2'b10,
        FALLA    = 2'b11
    } estado_t;

    typedef enum logic [1:0] {
        IN_RANGO = 2'b00,
        ALTO     = 2'b01,
        BAJO     = 2'b10,
        SENSOR   = 2'b11
    } clase_t;

endpackage

// File: rtl/canal_temp.sv
// One sensor channel: sample register, persistence filter,
// state machine and registered actuator enables.
module canal_temp
    import monitoreo_pkg::*;
#(
    parameter int TEMP_W  = 11,
    parameter int PERSIST = 5
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [TEMP_W-1:0] temp,
    input  logic              valida,
    input  logic [TEMP_W-1:0] umbral_alto,
    input  logic [TEMP_W-1:0] umbral_bajo,
    input  logic [TEMP_W-2:0] histeresis,
    input  logic              ack,
    output logic [1:0]        estado,
    output logic              calefactor,
    output logic              ventilador,
    output logic              falla,
    output logic              falla_next
);

    localparam logic [CNT_W-1:0] P_MAX = CNT_W'(PERSIST);
    localparam logic [TEMP_W-1:0] COD_MIN = {1'b1, {(TEMP_W-1){1'b0}}};

    logic signed [TEMP_W-1:0] muestra;
    logic signed [TEMP_W-1:0] alto_s;
    logic signed [TEMP_W-1:0] bajo_s;
    logic signed [TEMP_W:0]   m_ext;
    logic signed [TEMP_W:0]   lim_alto;
    logic signed [TEMP_W:0]   lim_bajo;
    logic                     pend;
    logic [CNT_W-1:0]         cnt, cnt_n;
    clase_t                   tag, tag_n, clase;
    estado_t                  est, est_n;
    logic                     lleno;

    assign alto_s = umbral_alto;
    assign bajo_s = umbral_bajo;

    // Sample capture; pend marks a fresh sample awaiting evaluation.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            muestra <= '0;
            pend    <= 1'b0;
        end else begin
            pend <= valida;
            if (valida) muestra <= temp;
        end
    end

    // Classify the registered sample; stuck-at-minimum means broken sensor.
    always_comb begin
        clase = IN_RANGO;
        if (muestra == COD_MIN) clase = SENSOR;
        else if (muestra > alto_s) clase = ALTO;
        else if (muestra < bajo_s) clase = BAJO;
    end

    // Exit limits widened by one bit so the margin cannot wrap.
    always_comb begin
        m_ext    = {muestra[TEMP_W-1], muestra};
        lim_alto = {alto_s[TEMP_W-1], alto_s} - $signed({2'b00, histeresis});
        lim_bajo = {bajo_s[TEMP_W-1], bajo_s} + $signed({2'b00, histeresis});
    end

    // Persistence counter and tag, advanced only on evaluation edges.
    always_comb begin
        cnt_n = cnt;
        tag_n = tag;
        if (pend) begin
            if (clase == IN_RANGO) begin
                cnt_n = '0;
                tag_n = IN_RANGO;
            end else if (clase == tag) begin
                if (cnt < P_MAX) cnt_n = cnt + 1'b1;
            end else begin
                cnt_n = CNT_W'(1);
                tag_n = clase;
            end
        end
        lleno = pend && (cnt_n == P_MAX);
    end

    // Next-state logic; a faulted sensor reading never counts as recovery.
    always_comb begin
        est_n = est;
        unique case (est)
            NORMAL: begin
                if (lleno) begin
                    unique case (tag_n)
                        ALTO:     est_n = CALIENTE;
                        BAJO:     est_n = FRIO;
                        SENSOR:   est_n = FALLA;
                        default:  est_n = NORMAL;
                    endcase
                end
            end
            CALIENTE: begin
                if (lleno && tag_n == SENSOR) est_n = FALLA;
                else if (pend && clase != SENSOR && m_ext <= lim_alto)
                    est_n = NORMAL;
            end
            FRIO: begin
                if (lleno && tag_n == SENSOR) est_n = FALLA;
                else if (pend && clase != SENSOR && m_ext >= lim_bajo)
                    est_n = NORMAL;
            end
            FALLA: begin
                if (ack && clase != SENSOR) est_n = NORMAL;
            end
            default: est_n = NORMAL;
        endcase
        falla_next = (est_n == FALLA);
    end

    // State, filter and decoded outputs all update together.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt        <= '0;
            tag        <= IN_RANGO;
            est        <= NORMAL;
            calefactor <= 1'b0;
            ventilador <= 1'b0;
            falla      <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            tag        <= tag_n;
            est        <= est_n;
            calefactor <= (est_n == FRIO);
            ventilador <= (est_n == CALIENTE);
            falla      <= (est_n == FALLA);
        end
    end

    assign estado = est;

endmodule

// File: rtl/monitoreo_multicanal.sv
// Multi-channel temperature monitor: N_CH independent channels
// plus a sticky global fault alert.
module monitoreo_multicanal
    import monitoreo_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int TEMP_W  = 11,
    parameter int PERSIST = 5
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [N_CH*TEMP_W-1:0] temp_entrada,
    input  logic [N_CH-1:0]        temp_valida,
    input  logic [TEMP_W-1:0]      umbral_alto,
    input  logic [TEMP_W-1:0]      umbral_bajo,
    input  logic [TEMP_W-2:0]      histeresis,
    input  logic                   alerta_ack,
    output logic [N_CH-1:0]        calefactor,
    output logic [N_CH-1:0]        ventilador,
    output logic [2*N_CH-1:0]      estado_actual,
    output logic                   alerta,
    output logic [N_CH-1:0]        alerta_canal
);

    logic [N_CH-1:0] falla_n;
    logic            entra;
    logic            alguna;

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        canal_temp #(
            .TEMP_W  (TEMP_W),
            .PERSIST (PERSIST)
        ) u_canal (
            .clk         (clk),
            .arst_n      (arst_n),
            .temp        (temp_entrada[i*TEMP_W +: TEMP_W]),
            .valida      (temp_valida[i]),
            .umbral_alto (umbral_alto),
            .umbral_bajo (umbral_bajo),
            .histeresis  (histeresis),
            .ack         (alerta_ack),
            .estado      (estado_actual[2*i +: 2]),
            .calefactor  (calefactor[i]),
            .ventilador  (ventilador[i]),
            .falla       (alerta_canal[i]),
            .falla_next  (falla_n[i])
        );
    end

    // Detect a fresh fault entry and whether any fault survives this edge.
    always_comb begin
        entra  = |(falla_n & ~alerta_canal);
        alguna = |falla_n;
    end

    // Sticky alert: a new fault entry beats a concurrent acknowledge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) alerta <= 1'b0;
        else if (entra) alerta <= 1'b1;
        else if (alerta_ack && !alguna) alerta <= 1'b0;
    end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Directed bench for monitoreo_multicanal with hand-computed
// expectations checked by immediate assertions.
module tb_monitoreo_multicanal;

    localparam int N_CH = 4;
    localparam int TW   = 11;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [N_CH*TW-1:0] temp_entrada;
    logic [N_CH-1:0]   temp_valida;
    logic [TW-1:0]     umbral_alto;
    logic [TW-1:0]     umbral_bajo;
    logic [TW-2:0]     histeresis;
    logic              alerta_ack;
    logic [N_CH-1:0]   calefactor;
    logic [N_CH-1:0]   ventilador;
    logic [2*N_CH-1:0] estado_actual;
    logic              alerta;
    logic [N_CH-1:0]   alerta_canal;

    int n_vec = 0;
    int n_bad = 0;

    monitoreo_multicanal #(.N_CH(4), .TEMP_W(11), .PERSIST(5)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .temp_entrada  (temp_entrada),
        .temp_valida   (temp_valida),
        .umbral_alto   (umbral_alto),
        .umbral_bajo   (umbral_bajo),
        .histeresis    (histeresis),
        .alerta_ack    (alerta_ack),
        .calefactor    (calefactor),
        .ventilador    (ventilador),
        .estado_actual (estado_actual),
        .alerta        (alerta),
        .alerta_canal  (alerta_canal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] est,
                           input logic [3:0] cal, input logic [3:0] ven,
                           input logic al, input logic [3:0] alc);
        chk({tag, ".estado"}, 32'(estado_actual), 32'(est));
        chk({tag, ".calef"}, 32'(calefactor), 32'(cal));
        chk({tag, ".vent"}, 32'(ventilador), 32'(ven));
        chk({tag, ".alerta"}, 32'(alerta), 32'(al));
        chk({tag, ".alc"}, 32'(alerta_canal), 32'(alc));
    endtask

    task automatic muestra(input int ch, input int v, input int n);
        logic [TW-1:0] t;
        t = TW'(v);
        for (int k = 0; k < n; k++) begin
            temp_entrada[ch*TW +: TW] = t;
            temp_valida = '0;
            temp_valida[ch] = 1'b1;
            tick();
        end
        temp_valida = '0;
    endtask

    initial begin
        arst_n       = 1'b0;
        temp_entrada = '0;
        temp_valida  = '0;
        umbral_alto  = 11'd300;
        umbral_bajo  = 11'd100;
        histeresis   = 10'd20;
        alerta_ack   = 1'b0;
        tick();
        tick();
        chk_all("reset", 8'h00, 4'h0, 4'h0, 1'b0, 4'h0);
        arst_n = 1'b1;

        // ch0 hot run
        muestra(0, 320, 5);
        chk("hot.pre", 32'(estado_actual), 32'h00);
        tick();
        chk_all("hot", 8'h02, 4'h0, 4'h1, 1'b0, 4'h0);
        muestra(0, 280, 1);
        tick();
        chk("hot.exit", 32'(estado_actual), 32'h00);

        // ch1 cold run broken by an in-range sample
        muestra(1, 50, 4);
        muestra(1, 150, 1);
        muestra(1, 50, 4);
        tick();
        chk("cold.4", 32'(estado_actual), 32'h00);
        muestra(1, 50, 1);
        tick();
        chk_all("cold", 8'h04, 4'h2, 4'h0, 1'b0, 4'h0);
        muestra(1, 115, 1);
        tick();
        chk("cold.115", 32'(estado_actual), 32'h04);
        muestra(1, 120, 1);
        tick();
        chk_all("cold.exit", 8'h00, 4'h0, 4'h0, 1'b0, 4'h0);

        // ch2 sensor fault and acknowledge
        muestra(2, -1024, 5);
        tick();
        chk_all("fault", 8'h30, 4'h0, 4'h0, 1'b1, 4'h4);
        alerta_ack = 1'b1;
        tick();
        alerta_ack = 1'b0;
        chk_all("fault.ack1", 8'h30, 4'h0, 4'h0, 1'b1, 4'h4);
        muestra(2, 200, 1);
        tick();
        chk("fault.held", 32'(estado_actual), 32'h30);
        alerta_ack = 1'b1;
        tick();
        alerta_ack = 1'b0;
        chk_all("fault.clr", 8'h00, 4'h0, 4'h0, 1'b0, 4'h0);

        // gap in valid strobes keeps the count
        muestra(0, 320, 3);
        for (int k = 0; k < 10; k++) tick();
        chk("gap.mid", 32'(estado_actual), 32'h00);
        muestra(0, 320, 2);
        chk("gap.pre", 32'(estado_actual), 32'h00);
        tick();
        chk("gap.hot", 32'(estado_actual), 32'h02);
        muestra(0, 200, 1);
        tick();
        chk("gap.exit", 32'(estado_actual), 32'h00);

        // reset in mid-persistence
        muestra(3, 400, 5);
        tick();
        chk("rst.ch3", 32'(estado_actual), 32'h80);
        muestra(0, 320, 4);
        tick();
        #2;
        arst_n = 1'b0;
        #1;
        chk_all("rst.async", 8'h00, 4'h0, 4'h0, 1'b0, 4'h0);
        #2;
        arst_n = 1'b1;
        muestra(0, 320, 4);
        tick();
        chk("rst.4", 32'(estado_actual), 32'h00);
        muestra(0, 320, 1);
        tick();
        chk_all("rst.hot", 8'h02, 4'h0, 4'h1, 1'b0, 4'h0);

        // fault entry on the same edge as acknowledge
        muestra(3, -1024, 5);
        alerta_ack = 1'b1;
        tick();
        alerta_ack = 1'b0;
        chk_all("setwins", 8'hC2, 4'h0, 4'h1, 1'b1, 4'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
